// File: rtl/uart_cmd_decoder.sv
// Assembles 6-byte packets (SYNC, OP, ADDR_H, ADDR_L, DATA, CHK) from the UART receiver byte stream
// and presents validated pixel/config writes on a valid/ready interface.
`timescale 1ns/1ps
module uart_cmd_decoder #(
  parameter int unsigned TIMEOUT   = 704,
  parameter logic [7:0]  SYNC_BYTE = 8'hA5
) (
  input  logic        clk_16bd,
  input  logic        rst,
  input  logic [8:0]  frame,
  input  logic        frame_valid,
  input  logic        cmd_ready,
  output logic        cmd_valid,
  output logic        cmd_op,
  output logic [15:0] cmd_addr,
  output logic [7:0]  cmd_data,
  output logic [7:0]  err_count,
  output logic        busy
);

  localparam logic [2:0] S_SYNC   = 3'd0;
  localparam logic [2:0] S_OPCODE = 3'd1;
  localparam logic [2:0] S_ADDRH  = 3'd2;
  localparam logic [2:0] S_ADDRL  = 3'd3;
  localparam logic [2:0] S_DATA   = 3'd4;
  localparam logic [2:0] S_CHECK  = 3'd5;
  localparam logic [2:0] S_ISSUE  = 3'd6;

  localparam logic [15:0] TMO_LAST = 16'(TIMEOUT - 1);

  logic [2:0]  state_q, state_d;
  logic [7:0]  op_q, op_d;
  logic [7:0]  addrh_q, addrh_d;
  logic [7:0]  addrl_q, addrl_d;
  logic [7:0]  data_q, data_d;
  logic [7:0]  xor_q, xor_d;
  logic [15:0] tmo_q, tmo_d;
  logic [7:0]  err_q, err_d;
  logic        valid_q, valid_d;
  logic        cop_q, cop_d;
  logic [15:0] caddr_q, caddr_d;
  logic [7:0]  cdata_q, cdata_d;
  logic        busy_q, busy_d;
  logic        errInc;
  logic [7:0]  rxByte;
  logic        unused_frame_msb;

  assign rxByte           = frame[7:0];
  assign unused_frame_msb = frame[8];

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    addrh_d = addrh_q;
    addrl_d = addrl_q;
    data_d  = data_q;
    xor_d   = xor_q;
    tmo_d   = tmo_q;
    valid_d = valid_q;
    cop_d   = cop_q;
    caddr_d = caddr_q;
    cdata_d = cdata_q;
    errInc  = 1'b0;

    case (state_q)
      S_SYNC: begin
        if (frame_valid && rxByte == SYNC_BYTE) begin
          state_d = S_OPCODE;
          tmo_d   = '0;
          xor_d   = '0;
        end
      end
      S_OPCODE, S_ADDRH, S_ADDRL, S_DATA: begin
        if (frame_valid) begin
          tmo_d = '0;
          xor_d = xor_q ^ rxByte;
          case (state_q)
            S_OPCODE: begin op_d    = rxByte; state_d = S_ADDRH; end
            S_ADDRH:  begin addrh_d = rxByte; state_d = S_ADDRL; end
            S_ADDRL:  begin addrl_d = rxByte; state_d = S_DATA;  end
            default:  begin data_d  = rxByte; state_d = S_CHECK; end
          endcase
        end else if (tmo_q == TMO_LAST) begin
          errInc  = 1'b1;
          state_d = S_SYNC;
        end else begin
          tmo_d = tmo_q + 16'd1;
        end
      end
      S_CHECK: begin
        if (frame_valid) begin
          tmo_d = '0;
          if (rxByte == xor_q && (op_q == 8'h01 || op_q == 8'h02)) begin
            state_d = S_ISSUE;
            valid_d = 1'b1;
            cop_d   = (op_q == 8'h02);
            caddr_d = {addrh_q, addrl_q};
            cdata_d = data_q;
          end else begin
            errInc  = 1'b1;
            state_d = S_SYNC;
          end
        end else if (tmo_q == TMO_LAST) begin
          errInc  = 1'b1;
          state_d = S_SYNC;
        end else begin
          tmo_d = tmo_q + 16'd1;
        end
      end
      S_ISSUE: begin
        // A byte landing while a command is held has nowhere to go, so it is dropped and counted.
        if (frame_valid) errInc = 1'b1;
        if (valid_q && cmd_ready) begin
          valid_d = 1'b0;
          state_d = S_SYNC;
        end
      end
      default: state_d = S_SYNC;
    endcase

    busy_d = (state_d != S_SYNC);
    err_d  = (errInc && err_q != 8'hFF) ? err_q + 8'd1 : err_q;
  end

  always_ff @(posedge clk_16bd or negedge rst) begin
    if (!rst) begin
      state_q <= S_SYNC;
      op_q    <= '0;
      addrh_q <= '0;
      addrl_q <= '0;
      data_q  <= '0;
      xor_q   <= '0;
      tmo_q   <= '0;
      err_q   <= '0;
      valid_q <= 1'b0;
      cop_q   <= 1'b0;
      caddr_q <= '0;
      cdata_q <= '0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      addrh_q <= addrh_d;
      addrl_q <= addrl_d;
      data_q  <= data_d;
      xor_q   <= xor_d;
      tmo_q   <= tmo_d;
      err_q   <= err_d;
      valid_q <= valid_d;
      cop_q   <= cop_d;
      caddr_q <= caddr_d;
      cdata_q <= cdata_d;
      busy_q  <= busy_d;
    end
  end

  assign cmd_valid = valid_q;
  assign cmd_op    = cop_q;
  assign cmd_addr  = caddr_q;
  assign cmd_data  = cdata_q;
  assign err_count = err_q;
  assign busy      = busy_q;

endmodule
